// File: rtl/mul_array_sequencer.sv
// Steps a ROW_NUM x COL_NUM multiply array one column per F period and sums
// each row's partial products. Row results leave through a valid/ready handshake.
module mul_array_sequencer #(
  parameter int COL_NUM_BIT = 6,
  parameter int ROW_NUM     = 16,
  parameter int COM_LENG    = 32,
  parameter int PP_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       F,
  input  logic                       start,
  input  logic [PP_W-1:0]            pp_in,
  output logic [COL_NUM_BIT-1:0]     col_idx,
  output logic [$clog2(ROW_NUM)-1:0] row_idx,
  output logic                       busy,
  output logic [COM_LENG-1:0]        res_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       done,
  output logic                       phase_err
);

  localparam int RB      = $clog2(ROW_NUM);
  localparam int COL_NUM = 1 << COL_NUM_BIT;
  localparam logic [COL_NUM_BIT-1:0] COL_LAST = COL_NUM_BIT'(COL_NUM - 1);
  localparam logic [RB-1:0]          ROW_LAST = RB'(ROW_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_f_q;
  logic [COL_NUM_BIT-1:0] r_col_idx;
  logic [RB-1:0]          r_row_idx;
  logic [COM_LENG-1:0]    r_acc;
  logic [COM_LENG-1:0]    r_res_data;
  logic                   r_res_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_phase_err;

  logic [COM_LENG-1:0]    w_acc_sum;
  logic                   w_viol;
  logic                   w_last_col;
  logic                   w_last_row;
  logic                   w_accept;

  // F must toggle on every clock while the array is being walked
  always_comb begin
    w_next_state = r_state;
    w_acc_sum    = r_acc + COM_LENG'(pp_in);
    w_last_col   = (r_col_idx == COL_LAST);
    w_last_row   = (r_row_idx == ROW_LAST);
    w_accept     = r_res_valid && res_ready;
    w_viol       = ((r_state == ST_ARM) || (r_state == ST_RUN)) && (F == r_f_q);
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_ARM;
        else       w_next_state = ST_IDLE;
      end
      ST_ARM: begin
        if (w_viol)  w_next_state = ST_IDLE;
        else if (F)  w_next_state = ST_RUN;
        else         w_next_state = ST_ARM;
      end
      ST_RUN: begin
        if (w_viol)                w_next_state = ST_IDLE;
        else if (F && w_last_col)  w_next_state = ST_HOLD;
        else                       w_next_state = ST_RUN;
      end
      ST_HOLD: begin
        if (w_accept) begin
          if (w_last_row) w_next_state = ST_IDLE;
          else            w_next_state = ST_ARM;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_q       <= 1'b1;
      r_col_idx   <= '0;
      r_row_idx   <= '0;
      r_acc       <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      r_f_q  <= F;
      r_done <= 1'b0;
      r_busy <= (w_next_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_col_idx   <= '0;
          r_row_idx   <= '0;
          r_acc       <= '0;
          r_res_valid <= 1'b0;
          if (start) r_phase_err <= 1'b0;
        end
        ST_ARM: begin
          if (w_viol) r_phase_err <= 1'b1;
        end
        ST_RUN: begin
          // A fault on the final sample wins over producing a result
          if (w_viol) begin
            r_phase_err <= 1'b1;
            r_res_valid <= 1'b0;
          end else if (F) begin
            r_acc <= w_acc_sum;
            if (w_last_col) begin
              r_res_data  <= w_acc_sum;
              r_res_valid <= 1'b1;
            end else begin
              r_col_idx <= r_col_idx + COL_NUM_BIT'(1);
            end
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_res_valid <= 1'b0;
            if (w_last_row) begin
              r_done <= 1'b1;
            end else begin
              r_row_idx <= r_row_idx + RB'(1);
              r_col_idx <= '0;
              r_acc     <= '0;
            end
          end
        end
        default: r_res_valid <= 1'b0;
      endcase
    end
  end

  assign col_idx   = r_col_idx;
  assign row_idx   = r_row_idx;
  assign busy      = r_busy;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign done      = r_done;
  assign phase_err = r_phase_err;

endmodule
